// File: rtl/mips_r2000_core.sv
// mips_r2000_core: single-cycle MIPS R2000 integer core (PC unit, IMem, register file, ALU, DMem, control).
// Define MIPS_SIGNED_OVF_EN to suppress the register write on signed overflow of add/sub/addi.
module mips_pcu (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic [31:0] pc_d,
  output logic [31:0] pc
);
  logic [31:0] PC;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) PC <= '0;
    else if (en) PC <= pc_d;
  assign pc = PC;
endmodule

module mips_imem (
  input  logic        CLK,
  input  logic        we,
  input  logic [9:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [9:0]  addr,
  output logic [31:0] rdata
);
  logic [31:0] IMem [0:1023];
  always_ff @(posedge CLK)
    if (we) IMem[waddr] <= wdata;
  assign rdata = IMem[addr];
endmodule

module mips_regfile (
  input  logic        CLK,
  input  logic        RST,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RF [0:31];
  always_ff @(posedge CLK or negedge RST)
    if (!RST) for (int i = 0; i < 32; i++) RF[i] <= '0;
    else if (we && wa != 5'd0) RF[wa] <= wd;
  assign rd1 = (ra1 == 5'd0) ? '0 : RF[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : RF[ra2];
endmodule

module mips_dmem (
  input  logic        CLK,
  input  logic        we,
  input  logic [9:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd
);
  logic [31:0] DMem [0:1023];
  always_ff @(posedge CLK)
    if (we) DMem[addr] <= wd;
  assign rd = DMem[addr];
endmodule

module mips_r2000_core (
  input logic CLK,
  input logic RST
);
`ifdef MIPS_SIGNED_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif
  logic        run_q, rf_we, dm_we, ovf_r, ovf_s, ovf_i;
  logic [31:0] pc, pc_d, pc4, instr, rs_v, rt_v, sext, zext, res, rdata;
  logic [31:0] sum, dif, isum, br_tgt, j_tgt;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh, wa;
  // Reset release is taken on a clock edge first, so nothing commits in the cycle RST rises.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) run_q <= 1'b0;
    else run_q <= 1'b1;
  mips_pcu U_PCU (.CLK(CLK), .RST(RST), .en(run_q), .pc_d(pc_d), .pc(pc));
  mips_imem U_InstructionMemory (
    .CLK(CLK), .we(1'b0), .waddr(10'd0), .wdata(32'd0), .addr(pc[11:2]), .rdata(instr)
  );
  mips_regfile U_RegFile (
    .CLK(CLK), .RST(RST), .we(rf_we && run_q), .wa(wa), .wd(res),
    .ra1(rs), .ra2(rt), .rd1(rs_v), .rd2(rt_v)
  );
  mips_dmem U_DataMemory (.CLK(CLK), .we(dm_we && run_q), .addr(isum[11:2]), .wd(rt_v), .rd(rdata));
  assign {op, rs, rt, rd, sh, fn} = instr;
  assign sext   = {{16{instr[15]}}, instr[15:0]};
  assign zext   = {16'h0, instr[15:0]};
  assign pc4    = pc + 32'd4;
  assign br_tgt = pc4 + {sext[29:0], 2'b00};
  assign j_tgt  = {pc4[31:28], instr[25:0], 2'b00};
  assign sum    = rs_v + rt_v;
  assign dif    = rs_v - rt_v;
  assign isum   = rs_v + sext;
  assign ovf_r  = (rs_v[31] == rt_v[31]) && (sum[31] != rs_v[31]);
  assign ovf_s  = (rs_v[31] != rt_v[31]) && (dif[31] != rs_v[31]);
  assign ovf_i  = (rs_v[31] == sext[31]) && (isum[31] != rs_v[31]);
  always_comb begin
    rf_we = 1'b0;
    dm_we = 1'b0;
    wa    = rt;
    res   = '0;
    pc_d  = pc4;
    case (op)
      6'h00: begin
        wa    = rd;
        rf_we = 1'b1;
        case (fn)
          6'h20: begin res = sum; rf_we = !(OVF_EN && ovf_r); end
          6'h21: res = sum;
          6'h22: begin res = dif; rf_we = !(OVF_EN && ovf_s); end
          6'h23: res = dif;
          6'h24: res = rs_v & rt_v;
          6'h25: res = rs_v | rt_v;
          6'h26: res = rs_v ^ rt_v;
          6'h27: res = ~(rs_v | rt_v);
          6'h2a: res = {31'd0, $signed(rs_v) < $signed(rt_v)};
          6'h2b: res = {31'd0, rs_v < rt_v};
          6'h00: res = rt_v << sh;
          6'h02: res = rt_v >> sh;
          6'h03: res = $signed(rt_v) >>> sh;
          6'h08: begin rf_we = 1'b0; pc_d = rs_v; end
          default: rf_we = 1'b0;
        endcase
      end
      6'h08: begin res = isum; rf_we = !(OVF_EN && ovf_i); end
      6'h09: begin res = isum; rf_we = 1'b1; end
      6'h0a: begin res = {31'd0, $signed(rs_v) < $signed(sext)}; rf_we = 1'b1; end
      6'h0b: begin res = {31'd0, rs_v < sext}; rf_we = 1'b1; end
      6'h0c: begin res = rs_v & zext; rf_we = 1'b1; end
      6'h0d: begin res = rs_v | zext; rf_we = 1'b1; end
      6'h0e: begin res = rs_v ^ zext; rf_we = 1'b1; end
      6'h0f: begin res = {instr[15:0], 16'h0}; rf_we = 1'b1; end
      6'h23: begin res = rdata; rf_we = 1'b1; end
      6'h2b: dm_we = 1'b1;
      6'h04: pc_d = (rs_v == rt_v) ? br_tgt : pc4;
      6'h05: pc_d = (rs_v != rt_v) ? br_tgt : pc4;
      6'h02: pc_d = j_tgt;
      6'h03: begin pc_d = j_tgt; wa = 5'd31; res = pc4; rf_we = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_r2000_core.sv
// tb_mips_r2000_core: directed program vectors for the single-cycle MIPS core, plus reset sequences.
module tb_mips_r2000_core;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mips_r2000_core dut (.CLK(CLK), .RST(RST));

`ifdef MIPS_SIGNED_OVF_EN
  localparam logic [31:0] E_ADD = 32'h0000_0055, E_ADDI = 32'h0, E_SUB = 32'h0;
`else
  localparam logic [31:0] E_ADD = 32'hFFFE_0000, E_ADDI = 32'h8000_0000, E_SUB = 32'h1;
`endif

  typedef struct {
    string              name;
    logic [19:0][31:0]  prog;
    int                 n;
    int                 nchk;
    logic [3:0][1:0]    kind;
    logic [3:0][9:0]    idx;
    logic [3:0][31:0]   exp;
  } vec_t;

  vec_t vq[$];
  vec_t cur;
  logic [19:0][31:0] p;
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] r_t(input int fn, input int rs, input int rt, input int rd, input int sh);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction
  function automatic logic [31:0] i_t(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] j_t(input int op, input int tgt);
    return {op[5:0], tgt[25:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  task automatic mk(input string nm, input int n);
    cur.name = nm;
    cur.prog = p;
    cur.n = n;
    cur.nchk = 0;
  endtask
  // kind: 0 = register, 1 = data memory word, 2 = PC
  task automatic ck(input int k, input int idx, input logic [31:0] e);
    cur.kind[cur.nchk] = k[1:0];
    cur.idx[cur.nchk] = idx[9:0];
    cur.exp[cur.nchk] = e;
    cur.nchk++;
    if (cur.nchk == 1) vq.push_back(cur);
    else vq[$] = cur;
  endtask

  function automatic logic [31:0] probe(input logic [1:0] k, input logic [9:0] idx);
    return (k == 2'd0) ? dut.U_RegFile.RF[idx[4:0]] :
           (k == 2'd1) ? dut.U_DataMemory.DMem[idx] : dut.U_PCU.PC;
  endfunction

  task automatic rf_zero(input string nm);
    int nz;
    nz = 0;
    for (int k = 0; k < 32; k++) if (dut.U_RegFile.RF[k] !== 32'h0) nz++;
    chk(nm, nz, 0);
  endtask

  task automatic load(input logic [19:0][31:0] pr);
    for (int k = 0; k < 1024; k++) dut.U_InstructionMemory.IMem[k] <= 32'h0;
    for (int k = 0; k < 20; k++) dut.U_InstructionMemory.IMem[k] <= pr[k];
  endtask

  task automatic load_and_start(input logic [19:0][31:0] pr);
    @(negedge CLK);
    RST = 1'b0;
    load(pr);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    p = '0;
    p[0] = i_t('h0d, 0, 1, 'h1234);
    p[1] = i_t('h0f, 0, 2, 'h8000);
    p[2] = r_t('h21, 1, 2, 3, 0);
    p[3] = r_t('h03, 0, 2, 4, 4);
    p[4] = r_t('h2b, 1, 2, 5, 0);
    mk("alu", 5); ck(0, 3, 32'h8000_1234); ck(0, 4, 32'hF800_0000); ck(0, 5, 32'h1); ck(2, 0, 32'h14);

    p = '0;
    p[0] = i_t('h08, 0, 1, 8);
    p[1] = i_t('h2b, 1, 1, 4);
    p[2] = i_t('h23, 0, 2, 12);
    p[3] = i_t('h08, 0, 3, -4);
    p[4] = i_t('h2b, 3, 3, 'h14);
    p[5] = i_t('h23, 0, 4, 'h1013);
    mk("mem_a", 3); ck(1, 3, 32'h8); ck(0, 2, 32'h8); ck(2, 0, 32'hC);
    mk("mem_wrap", 6); ck(1, 4, 32'hFFFF_FFFC); ck(0, 4, 32'hFFFF_FFFC); ck(2, 0, 32'h18);

    p = '0;
    p[0] = i_t('h04, 0, 0, 2);
    p[1] = i_t('h0d, 0, 7, 'h77);
    p[2] = i_t('h0d, 0, 7, 'h77);
    p[3] = j_t('h03, 'h10);
    p[4] = i_t('h05, 0, 0, 5);
    p[5] = i_t('h0d, 0, 8, 'h88);
    p[16] = r_t('h08, 31, 0, 0, 0);
    mk("beq", 1); ck(2, 0, 32'hC);
    mk("jal", 2); ck(2, 0, 32'h40); ck(0, 31, 32'h10);
    mk("jr", 3); ck(2, 0, 32'h10);
    mk("bne_nt", 5); ck(2, 0, 32'h18); ck(0, 8, 32'h88); ck(0, 7, 32'h0);

    p = '0;
    p[0] = i_t('h0d, 0, 1, 1);
    p[1] = i_t('h05, 1, 0, 1);
    p[2] = i_t('h0d, 0, 2, 'h22);
    p[3] = i_t('h0d, 0, 3, 3);
    p[4] = i_t('h04, 0, 0, -5);
    mk("br_back", 4); ck(2, 0, 32'h0); ck(0, 2, 32'h0); ck(0, 3, 32'h3); ck(0, 1, 32'h1);

    p = '0;
    p[0] = i_t('h0d, 0, 1, 9);
    p[1] = i_t('h08, 0, 0, 5);
    p[2] = r_t('h21, 0, 0, 1, 0);
    p[3] = i_t('h0d, 0, 5, 'h55);
    p[4] = 32'hFC05_1234;
    p[5] = r_t('h3f, 5, 5, 5, 0);
    mk("zero_nop", 6); ck(0, 0, 32'h0); ck(0, 1, 32'h0); ck(0, 5, 32'h55); ck(2, 0, 32'h18);

    p = '0;
    p[0] = i_t('h0f, 0, 1, 'h7fff);
    p[1] = i_t('h0d, 0, 2, 'h55);
    p[2] = r_t('h20, 1, 1, 2, 0);
    p[3] = r_t('h21, 1, 1, 3, 0);
    p[4] = i_t('h0f, 0, 6, 'h7fff);
    p[5] = i_t('h0d, 6, 6, 'hffff);
    p[6] = i_t('h08, 6, 4, 1);
    p[7] = i_t('h09, 6, 7, 1);
    p[8] = i_t('h0f, 0, 9, 'h8000);
    p[9] = r_t('h22, 9, 6, 10, 0);
    mk("ovf_a", 10); ck(0, 2, E_ADD); ck(0, 3, 32'hFFFE_0000); ck(0, 4, E_ADDI); ck(0, 7, 32'h8000_0000);
    mk("ovf_b", 10); ck(0, 10, E_SUB); ck(2, 0, 32'h28);

    p = '0;
    p[0] = i_t('h0d, 0, 1, 'hf0f0);
    p[1] = i_t('h0d, 0, 2, 'h0ff0);
    p[2] = r_t('h24, 1, 2, 3, 0);
    p[3] = r_t('h25, 1, 2, 4, 0);
    p[4] = r_t('h26, 1, 2, 5, 0);
    p[5] = r_t('h27, 1, 2, 6, 0);
    p[6] = r_t('h22, 2, 1, 7, 0);
    p[7] = r_t('h2a, 7, 1, 8, 0);
    p[8] = r_t('h2b, 7, 1, 9, 0);
    p[9] = r_t('h00, 0, 1, 10, 4);
    p[10] = r_t('h02, 0, 7, 11, 16);
    p[11] = i_t('h0c, 7, 12, 'hffff);
    p[12] = i_t('h0e, 1, 13, 'hffff);
    p[13] = i_t('h0a, 7, 14, -1);
    p[14] = i_t('h0b, 1, 15, -1);
    p[15] = i_t('h09, 0, 16, -2);
    p[16] = r_t('h23, 1, 2, 17, 0);
    mk("logic", 17); ck(0, 3, 32'h00F0); ck(0, 4, 32'hFFF0); ck(0, 5, 32'hFF00); ck(0, 6, 32'hFFFF_000F);
    mk("cmp_sh", 17); ck(0, 7, 32'hFFFF_1F00); ck(0, 8, 32'h1); ck(0, 9, 32'h0); ck(0, 10, 32'h000F_0F00);
    mk("imm", 17); ck(0, 11, 32'h0000_FFFF); ck(0, 12, 32'h1F00); ck(0, 13, 32'h0F0F); ck(0, 14, 32'h1);
    mk("imm2", 17); ck(0, 15, 32'h1); ck(0, 16, 32'hFFFF_FFFE); ck(0, 17, 32'hE100); ck(2, 0, 32'h44);

    // Power-on reset, hold, and the synchronized release
    #2 RST = 1'b0;
    #1;
    chk("por_pc", dut.U_PCU.PC, 32'h0);
    rf_zero("por_rf");
    load(vq[0].prog);
    repeat (3) @(negedge CLK);
    chk("hold_pc", dut.U_PCU.PC, 32'h0);
    chk("hold_r1", dut.U_RegFile.RF[1], 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    chk("sync_edge_pc", dut.U_PCU.PC, 32'h0);
    @(negedge CLK);
    chk("first_fetch_pc", dut.U_PCU.PC, 32'h4);
    chk("first_fetch_r1", dut.U_RegFile.RF[1], 32'h1234);

    foreach (vq[i]) begin
      load_and_start(vq[i].prog);
      repeat (vq[i].n) @(negedge CLK);
      for (int c = 0; c < vq[i].nchk; c++)
        chk($sformatf("%s#%0d", vq[i].name, c), probe(vq[i].kind[c], vq[i].idx[c]), vq[i].exp[c]);
    end

    // Asynchronous reset in the middle of a program
    load_and_start(vq[0].prog);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("mid_pc", dut.U_PCU.PC, 32'h0);
    rf_zero("mid_rf");
    chk("mid_dmem_kept", dut.U_DataMemory.DMem[3], 32'h8);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_sync_pc", dut.U_PCU.PC, 32'h0);
    @(negedge CLK);
    chk("mid_restart_pc", dut.U_PCU.PC, 32'h4);
    chk("mid_restart_r1", dut.U_RegFile.RF[1], 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
